instr_fetch_reader: RTL

Byte-serial instruction fetch reader for the 8-bit core. It fetches 16-bit instruction words from the byte-wide program memory port using a req/ack handshake, assembling them little-endian (low byte at the even address). Each completed word is presented with its PC to the instruction decoder over a valid/ready handshake. It owns the fetch PC and supports a flushing PC load for branches and jumps.

---
 rtl/instr_fetch_reader.sv | 99 +++++++++
 1 files changed

// File: rtl/instr_fetch_reader.sv
// instr_fetch_reader: byte-serial 16-bit little-endian instruction fetch with valid/ready output and flushing PC load
module instr_fetch_reader #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        tb_clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        pc_load,
    input  logic [15:0] pc_load_addr,
    output logic [15:0] instr_out,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  fetch_count
);
    typedef enum logic [1:0] {FETCH_LO, FETCH_HI, HOLD} state_t;

    localparam logic [15:0] START_PC = {RESET_PC[15:1], 1'b0};

    state_t      r_state;
    logic [15:0] r_fetch_pc;
    logic [7:0]  r_lo;
    logic        r_mem_req;
    logic [15:0] r_mem_addr;
    logic [15:0] r_instr_out;
    logic [15:0] r_instr_pc;
    logic        r_instr_valid;
    logic [7:0]  r_fetch_count;

    logic        w_xfer;
    logic        w_accept;
    logic [15:0] w_load_pc;

    assign w_xfer    = r_mem_req & mem_ack;
    assign w_accept  = r_instr_valid & instr_ready;
    assign w_load_pc = pc_load_addr & 16'hFFFE;

    // Fetch FSM: reset beats pc_load, pc_load beats any handshake completing on the same edge
    always_ff @(posedge tb_clk) begin
        if (reset) begin
            r_state       <= FETCH_LO;
            r_fetch_pc    <= START_PC;
            r_lo          <= 8'h00;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= START_PC;
            r_instr_out   <= 16'h0000;
            r_instr_pc    <= 16'h0000;
            r_instr_valid <= 1'b0;
            r_fetch_count <= 8'h00;
        end else if (pc_load) begin
            r_state       <= FETCH_LO;
            r_fetch_pc    <= w_load_pc;
            r_mem_addr    <= w_load_pc;
            r_mem_req     <= 1'b1;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                FETCH_LO: begin
                    r_mem_req <= 1'b1;
                    if (w_xfer) begin
                        r_lo       <= mem_rdata;
                        r_mem_addr <= r_fetch_pc + 16'd1;
                        r_state    <= FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (w_xfer) begin
                        r_instr_out   <= {mem_rdata, r_lo};
                        r_instr_pc    <= r_fetch_pc;
                        r_instr_valid <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_fetch_pc    <= r_fetch_pc + 16'd2;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_instr_valid <= 1'b0;
                        r_fetch_count <= r_fetch_count + 8'd1;
                        r_mem_req     <= 1'b1;
                        r_mem_addr    <= r_fetch_pc;
                        r_state       <= FETCH_LO;
                    end
                end
                default: r_state <= FETCH_LO;
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_out   = r_instr_out;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign fetch_count = r_fetch_count;
endmodule
